// File: rtl/key_event.sv
// Turns four debounced active-low key levels into registered single-cycle
// press / release / long / repeat events plus a held level, one FSM per key.
`timescale 1ns/1ps
module key_event #(
  parameter int LONG_CYCLES   = 25000000,
  parameter int REPEAT_CYCLES = 5000000,
  parameter bit REPEAT_EN     = 1'b1,
  parameter int CNT_W         = 26
) (
  input  logic       clk50M,
  input  logic       rst_n,
  input  logic [3:0] keys_n,
  output logic [3:0] press,
  output logic [3:0] rel,     // release event; 'release' is a reserved word
  output logic [3:0] long,
  output logic [3:0] rpt,
  output logic [3:0] held
);

  localparam logic [CNT_W-1:0] LONG_TERM = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] RPT_TERM  = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESSED  = 2'd1,
    LONGHELD = 2'd2
  } state_t;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_key
      state_t           state_q, state_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             press_q, press_d;
      logic             rel_q, rel_d;
      logic             long_q, long_d;
      logic             rpt_q, rpt_d;
      logic             held_q, held_d;

      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        long_d  = 1'b0;
        rpt_d   = 1'b0;
        held_d  = held_q;
        case (state_q)
          IDLE: begin
            if (!keys_n[gi]) begin
              state_d = PRESSED;
              press_d = 1'b1;
              held_d  = 1'b1;
              cnt_d   = '0;
            end
          end
          PRESSED: begin
            // A release always beats a terminal count on the same edge.
            if (keys_n[gi]) begin
              state_d = IDLE;
              rel_d   = 1'b1;
              held_d  = 1'b0;
              cnt_d   = '0;
            end else if (cnt_q == LONG_TERM) begin
              state_d = LONGHELD;
              long_d  = 1'b1;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
          LONGHELD: begin
            if (keys_n[gi]) begin
              state_d = IDLE;
              rel_d   = 1'b1;
              held_d  = 1'b0;
              cnt_d   = '0;
            end else if (REPEAT_EN) begin
              if (cnt_q == RPT_TERM) begin
                rpt_d = 1'b1;
                cnt_d = '0;
              end else begin
                cnt_d = cnt_q + CNT_ONE;
              end
            end else if (cnt_q != RPT_TERM) begin
              // Without auto-repeat the counter parks at terminal.
              cnt_d = cnt_q + CNT_ONE;
            end
          end
          default: begin
            state_d = IDLE;
            cnt_d   = '0;
            held_d  = 1'b0;
          end
        endcase
      end

      always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
          state_q <= IDLE;
          cnt_q   <= '0;
          press_q <= 1'b0;
          rel_q   <= 1'b0;
          long_q  <= 1'b0;
          rpt_q   <= 1'b0;
          held_q  <= 1'b0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
          press_q <= press_d;
          rel_q   <= rel_d;
          long_q  <= long_d;
          rpt_q   <= rpt_d;
          held_q  <= held_d;
        end
      end

      assign press[gi] = press_q;
      assign rel[gi]   = rel_q;
      assign long[gi]  = long_q;
      assign rpt[gi]   = rpt_q;
      assign held[gi]  = held_q;
    end
  endgenerate

endmodule

// File: tb/tb_key_event.sv
// Directed bench for key_event: a hold-time reference model predicts each
// cycle's outputs into a queue; the queue is popped after every clock edge.
`timescale 1ns/1ps
module tb_key_event;

  localparam int LONG = 8;
  localparam int REP  = 4;

  typedef struct packed {
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] lng;
    logic [3:0] rpt;
    logic [3:0] held;
  } exp_t;

  logic       clk50M;
  logic       rst_n;
  logic [3:0] ka, kb;
  logic [3:0] a_press, a_rel, a_long, a_rpt, a_held;
  logic [3:0] b_press, b_rel, b_long, b_rpt, b_held;

  int   checks;
  int   errors;
  int   step_no;
  int   low_t[2][4];
  exp_t q_a[$];
  exp_t q_b[$];

  key_event #(.LONG_CYCLES(LONG), .REPEAT_CYCLES(REP), .REPEAT_EN(1'b1), .CNT_W(4)) dut_a (
    .clk50M(clk50M), .rst_n(rst_n), .keys_n(ka),
    .press(a_press), .rel(a_rel), .long(a_long), .rpt(a_rpt), .held(a_held)
  );

  key_event #(.LONG_CYCLES(LONG), .REPEAT_CYCLES(REP), .REPEAT_EN(1'b0), .CNT_W(4)) dut_b (
    .clk50M(clk50M), .rst_n(rst_n), .keys_n(kb),
    .press(b_press), .rel(b_rel), .long(b_long), .rpt(b_rpt), .held(b_held)
  );

  initial clk50M = 1'b0;
  always #10 clk50M = ~clk50M;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Hold-time model: t counts edges since the press edge.
  task automatic model(input int d, input logic [3:0] k, input bit ren, output exp_t e);
    e = '0;
    for (int i = 0; i < 4; i++) begin
      if (!rst_n) begin
        low_t[d][i] = -1;
      end else if (k[i] == 1'b0) begin
        if (low_t[d][i] < 0) begin
          low_t[d][i] = 0;
          e.press[i] = 1'b1;
        end else begin
          low_t[d][i] = low_t[d][i] + 1;
          if (low_t[d][i] == LONG) e.lng[i] = 1'b1;
          if (ren && low_t[d][i] > LONG && ((low_t[d][i] - LONG) % REP) == 0) e.rpt[i] = 1'b1;
        end
        e.held[i] = 1'b1;
      end else begin
        if (low_t[d][i] >= 0) e.rel[i] = 1'b1;
        low_t[d][i] = -1;
      end
    end
  endtask

  task automatic cmp(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s step=%0d observed=%b expected=%b", tag, step_no, obs, exp);
    end
  endtask

  task automatic check_outputs();
    exp_t ea, eb;
    checks++;
    assert (q_a.size() > 0 && q_b.size() > 0) else begin
      errors++;
      $error("FAIL scoreboard_empty step=%0d observed=%0d/%0d expected=nonzero", step_no, q_a.size(), q_b.size());
    end
    if (q_a.size() > 0 && q_b.size() > 0) begin
      ea = q_a.pop_front();
      eb = q_b.pop_front();
      cmp("a_press", a_press, ea.press);
      cmp("a_release", a_rel, ea.rel);
      cmp("a_long", a_long, ea.lng);
      cmp("a_rpt", a_rpt, ea.rpt);
      cmp("a_held", a_held, ea.held);
      cmp("b_press", b_press, eb.press);
      cmp("b_release", b_rel, eb.rel);
      cmp("b_long", b_long, eb.lng);
      cmp("b_rpt", b_rpt, eb.rpt);
      cmp("b_held", b_held, eb.held);
      $display("step %0d rst_n=%b ka=%b kb=%b | A p=%b r=%b l=%b rp=%b h=%b | B p=%b r=%b l=%b rp=%b h=%b",
               step_no, rst_n, ka, kb, a_press, a_rel, a_long, a_rpt, a_held,
               b_press, b_rel, b_long, b_rpt, b_held);
    end
    step_no++;
  endtask

  task automatic step(input logic [3:0] a, input logic [3:0] b);
    exp_t ea, eb;
    ka = a;
    kb = b;
    model(0, a, 1'b1, ea);
    model(1, b, 1'b0, eb);
    q_a.push_back(ea);
    q_b.push_back(eb);
    @(posedge clk50M);
    #1;
    check_outputs();
  endtask

  // Asserts reset between edges and checks that outputs clear at once.
  task automatic reset_now();
    exp_t z;
    z = '0;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 4; i++) low_t[d][i] = -1;
    q_a.push_back(z);
    q_b.push_back(z);
    #1;
    check_outputs();
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    step_no = 0;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 4; i++) low_t[d][i] = -1;
    rst_n = 1'b0;
    ka = 4'hF;
    kb = 4'hF;

    repeat (3) step(4'hF, 4'hF);
    rst_n = 1'b1;
    repeat (20) step(4'hF, 4'hF);

    // Key 0 long hold with two repeats, released at E0+19.
    repeat (19) step(4'b1110, 4'hF);
    repeat (4) step(4'hF, 4'hF);

    // Key 2 short press, then release exactly on the long terminal edge.
    repeat (3) step(4'b1011, 4'hF);
    repeat (3) step(4'hF, 4'hF);
    repeat (8) step(4'b1011, 4'hF);
    repeat (3) step(4'hF, 4'hF);

    // Repeat disabled: key 1 held 30 clocks on the second instance.
    repeat (30) step(4'hF, 4'b1101);
    repeat (3) step(4'hF, 4'hF);

    // One-cycle low glitch.
    step(4'b1101, 4'hF);
    repeat (3) step(4'hF, 4'hF);

    // Key 3 held through a reset pulse.
    repeat (5) step(4'b0111, 4'hF);
    reset_now();
    repeat (2) step(4'b0111, 4'hF);
    rst_n = 1'b1;
    repeat (11) step(4'b0111, 4'hF);
    repeat (3) step(4'hF, 4'hF);

    // Keys 0 and 1 together.
    repeat (10) step(4'b1100, 4'b1100);
    repeat (3) step(4'hF, 4'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
